// File: rtl/bus_pkg.sv
// Shared types and helpers for the registered bus arbiter/mux.
package bus_pkg;

    localparam int BUS_W = 16;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Last-winner pointer plus combinational winner search (round-robin or fixed priority).
module rr_arbiter
    import bus_pkg::*;
#(
    parameter int N_SRC = 4,
    localparam int IW   = idx_w(N_SRC)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [N_SRC-1:0] req,
    input  logic             hold,
    input  arb_mode_t        mode,
    output logic [IW-1:0]    winner,
    output logic             any_req
);

    logic [IW-1:0] r_ptr;
    logic          w_found;
    int            w_idx;

    // RR search starts one past the last winner, so r_ptr itself is checked last.
    always_comb begin
        winner  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        any_req = |req;
        if (mode == ARB_RR) begin
            for (int k = 1; k <= N_SRC; k++) begin
                w_idx = int'(r_ptr) + k;
                if (w_idx >= N_SRC) w_idx = w_idx - N_SRC;
                if (!w_found && req[w_idx[IW-1:0]]) begin
                    winner  = w_idx[IW-1:0];
                    w_found = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (!w_found && req[i]) begin
                    winner  = IW'(i);
                    w_found = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ptr <= IW'(N_SRC - 1);
        end else if (!hold && any_req && mode == ARB_RR) begin
            r_ptr <= winner;
        end
    end

endmodule

// File: rtl/rr_bus_arbiter_mux.sv
// Registered shared-bus driver: arbitrates N_SRC requesters and registers the winner's data.
module rr_bus_arbiter_mux
    import bus_pkg::*;
#(
    parameter int WIDTH   = BUS_W,
    parameter int N_SRC   = 4,
    parameter int MODE_RR = 1,
    localparam int IW     = idx_w(N_SRC)
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [N_SRC-1:0]       req,
    input  logic [N_SRC*WIDTH-1:0] data_in,
    input  logic                   hold,
    output logic [N_SRC-1:0]       grant,
    output logic [IW-1:0]          grant_idx,
    output logic [WIDTH-1:0]       bus_out,
    output logic                   bus_valid
);

    localparam arb_mode_t MODE = (MODE_RR != 0) ? ARB_RR : ARB_FIXED;

    logic [IW-1:0]    w_winner;
    logic             w_any_req;
    logic [WIDTH-1:0] w_src [N_SRC];
    logic [WIDTH-1:0] w_sel;

    logic [N_SRC-1:0] r_grant;
    logic [IW-1:0]    r_grant_idx;
    logic [WIDTH-1:0] r_bus_out;
    logic             r_bus_valid;

    rr_arbiter #(.N_SRC(N_SRC)) u_arb (
        .Clk     (Clk),
        .Reset   (Reset),
        .req     (req),
        .hold    (hold),
        .mode    (MODE),
        .winner  (w_winner),
        .any_req (w_any_req)
    );

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        assign w_src[g] = data_in[g*WIDTH +: WIDTH];
    end

    assign w_sel = w_src[w_winner];

    // Idle cycles drop grant/valid but keep bus_out and grant_idx from the last transfer.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_bus_out   <= '0;
            r_bus_valid <= 1'b0;
        end else if (!hold) begin
            if (w_any_req) begin
                r_grant     <= N_SRC'(1) << w_winner;
                r_grant_idx <= w_winner;
                r_bus_out   <= w_sel;
                r_bus_valid <= 1'b1;
            end else begin
                r_grant     <= '0;
                r_bus_valid <= 1'b0;
            end
        end
    end

    assign grant     = r_grant;
    assign grant_idx = r_grant_idx;
    assign bus_out   = r_bus_out;
    assign bus_valid = r_bus_valid;

endmodule

// File: tb/tb_rr_bus_arbiter_mux.sv
// Scoreboard bench: one round-robin and one fixed-priority instance, directed vectors.
module tb_rr_bus_arbiter_mux;

    typedef struct packed {
        logic [3:0]  g;
        logic [1:0]  ix;
        logic [15:0] bus;
        logic        v;
    } exp_t;

    logic        Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        rst_a = 1'b1, hold_a = 1'b0, rst_b = 1'b1, hold_b = 1'b0;
    logic [3:0]  req_a = '0, req_b = '0;
    logic [63:0] din_a = '0, din_b = '0;
    logic [3:0]  g_a, g_b;
    logic [1:0]  ix_a, ix_b;
    logic [15:0] bus_a, bus_b;
    logic        v_a, v_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    rr_bus_arbiter_mux #(.WIDTH(16), .N_SRC(4), .MODE_RR(1)) u_rr (
        .Clk(Clk), .Reset(rst_a), .req(req_a), .data_in(din_a), .hold(hold_a),
        .grant(g_a), .grant_idx(ix_a), .bus_out(bus_a), .bus_valid(v_a)
    );

    rr_bus_arbiter_mux #(.WIDTH(16), .N_SRC(4), .MODE_RR(0)) u_fx (
        .Clk(Clk), .Reset(rst_b), .req(req_b), .data_in(din_b), .hold(hold_b),
        .grant(g_b), .grant_idx(ix_b), .bus_out(bus_b), .bus_valid(v_b)
    );

    localparam logic [63:0] D_ABCD = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};

    int step_no = 0;

    task automatic step(input bit sel, input bit rst, input bit hld, input logic [3:0] rq,
                        input logic [63:0] din, input logic [3:0] eg, input logic [1:0] eix,
                        input logic [15:0] ebus, input logic ev);
        exp_t e;
        @(negedge Clk);
        e = '{g: eg, ix: eix, bus: ebus, v: ev};
        if (!sel) begin
            rst_a = rst; hold_a = hld; req_a = rq; din_a = din; q_a.push_back(e);
        end else begin
            rst_b = rst; hold_b = hld; req_b = rq; din_b = din; q_b.push_back(e);
        end
    endtask

    task automatic check(input string nm, input exp_t e, input exp_t a);
        n_cmp++;
        if (a !== e || (a.v !== (|a.g)) || ($countones(a.g) > 1)) begin
            n_bad++;
            $display("FAIL %s: got grant=%b idx=%0d bus=%h valid=%b, want grant=%b idx=%0d bus=%h valid=%b",
                     nm, a.g, a.ix, a.bus, a.v, e.g, e.ix, e.bus, e.v);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check($sformatf("rr_cyc%0d", n_cmp), e, '{g: g_a, ix: ix_a, bus: bus_a, v: v_a});
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check($sformatf("fx_cyc%0d", n_cmp), e, '{g: g_b, ix: ix_b, bus: bus_b, v: v_b});
            end
        end
    end

    initial begin : stim
        logic [63:0] d2;
        // Round-robin instance: reset, then rotation with wrap.
        step(0, 1, 0, 4'b1111, D_ABCD, 4'b0000, 2'd0, 16'h0000, 0);
        step(0, 1, 0, 4'b1111, D_ABCD, 4'b0000, 2'd0, 16'h0000, 0);
        step(0, 0, 0, 4'b1111, D_ABCD, 4'b0001, 2'd0, 16'hAAAA, 1);
        step(0, 0, 0, 4'b1111, D_ABCD, 4'b0010, 2'd1, 16'hBBBB, 1);
        step(0, 0, 0, 4'b1111, D_ABCD, 4'b0100, 2'd2, 16'hCCCC, 1);
        step(0, 0, 0, 4'b1111, D_ABCD, 4'b1000, 2'd3, 16'hDDDD, 1);
        step(0, 0, 0, 4'b1111, D_ABCD, 4'b0001, 2'd0, 16'hAAAA, 1);
        // Sole requester wins on consecutive edges.
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 4'b0010, D_ABCD, 4'b0010, 2'd1, 16'hBBBB, 1);
        // Idle and hold.
        d2 = {16'hDDDD, 16'h1234, 16'hBBBB, 16'hAAAA};
        step(0, 0, 0, 4'b0100, d2, 4'b0100, 2'd2, 16'h1234, 1);
        step(0, 0, 0, 4'b0000, d2, 4'b0000, 2'd2, 16'h1234, 0);
        d2 = {16'hDDDD, 16'h5678, 16'hBBBB, 16'hAAAA};
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 4'b0100, d2, 4'b0000, 2'd2, 16'h1234, 0);
        step(0, 0, 0, 4'b0100, d2, 4'b0100, 2'd2, 16'h5678, 1);
        // Pointer now 2: reset must restore source-0 priority.
        step(0, 1, 0, 4'b1111, D_ABCD, 4'b0000, 2'd0, 16'h0000, 0);
        step(0, 0, 0, 4'b1111, D_ABCD, 4'b0001, 2'd0, 16'hAAAA, 1);
        // Hold freezes an active grant, then rotation resumes.
        step(0, 0, 1, 4'b1111, D_ABCD, 4'b0001, 2'd0, 16'hAAAA, 1);
        step(0, 0, 0, 4'b1111, D_ABCD, 4'b0010, 2'd1, 16'hBBBB, 1);
        step(0, 0, 0, 4'b1010, D_ABCD, 4'b1000, 2'd3, 16'hDDDD, 1);
        step(0, 0, 0, 4'b1010, D_ABCD, 4'b0010, 2'd1, 16'hBBBB, 1);

        // Fixed-priority instance.
        step(1, 1, 0, 4'b1111, D_ABCD, 4'b0000, 2'd0, 16'h0000, 0);
        step(1, 1, 0, 4'b1111, D_ABCD, 4'b0000, 2'd0, 16'h0000, 0);
        for (int i = 0; i < 4; i++)
            step(1, 0, 0, 4'b1010, D_ABCD, 4'b0010, 2'd1, 16'hBBBB, 1);
        step(1, 0, 0, 4'b1000, D_ABCD, 4'b1000, 2'd3, 16'hDDDD, 1);
        step(1, 0, 0, 4'b0000, D_ABCD, 4'b0000, 2'd3, 16'hDDDD, 0);
        step(1, 0, 0, 4'b0101, D_ABCD, 4'b0001, 2'd0, 16'hAAAA, 1);
        step(1, 0, 1, 4'b0100, D_ABCD, 4'b0001, 2'd0, 16'hAAAA, 1);
        step(1, 0, 0, 4'b0100, D_ABCD, 4'b0100, 2'd2, 16'hCCCC, 1);

        for (int i = 0; i < 20 && (q_a.size() + q_b.size()) > 0; i++) @(posedge Clk);
        #2;
        n_cmp++;
        if ((q_a.size() + q_b.size()) != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, want 0", q_a.size() + q_b.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
